// File: rtl/y86_regs_pkg.sv
// Y86-64 register IDs and write-back scheduler state encoding.
package y86_regs_pkg;

    localparam logic [3:0] REG_RAX  = 4'h0;
    localparam logic [3:0] REG_RCX  = 4'h1;
    localparam logic [3:0] REG_RDX  = 4'h2;
    localparam logic [3:0] REG_RBX  = 4'h3;
    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_RBP  = 4'h5;
    localparam logic [3:0] REG_RSI  = 4'h6;
    localparam logic [3:0] REG_RDI  = 4'h7;
    localparam logic [3:0] REG_R8   = 4'h8;
    localparam logic [3:0] REG_R9   = 4'h9;
    localparam logic [3:0] REG_R10  = 4'hA;
    localparam logic [3:0] REG_R11  = 4'hB;
    localparam logic [3:0] REG_R12  = 4'hC;
    localparam logic [3:0] REG_R13  = 4'hD;
    localparam logic [3:0] REG_R14  = 4'hE;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } wb_state_t;

endpackage

// File: rtl/regfile_wb_sched.sv
// Serialises a dual-destination write-back into single-port register-file writes
// and tracks which registers still have an accepted write in flight.
//
// state  | meaning
// IDLE   | ready for a request; presents the first/only write of the last accept
// SECOND | presenting-next the held E write; no request accepted
module regfile_wb_sched
    import y86_regs_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   pending
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    logic [3:0]        r_hold_addr;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_wr_en;
    logic [3:0]        r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [NREG-1:0]   r_pending;

    logic              w_accept;
    logic              w_e_vld;
    logic              w_m_vld;
    logic              w_hold_load;
    logic              w_wr_en_nxt;
    logic [3:0]        w_wr_addr_nxt;
    logic [DATA_W-1:0] w_wr_data_nxt;
    logic [3:0]        w_set_a;
    logic [3:0]        w_set_b;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;

    assign wb_ready = rst_n && (r_state == IDLE);
    assign w_accept = wb_valid && wb_ready;
    assign w_e_vld  = (dstE != REG_NONE);
    assign w_m_vld  = (dstM != REG_NONE);

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_load   = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = REG_NONE;
        w_wr_data_nxt = '0;
        w_set_a       = REG_NONE;
        w_set_b       = REG_NONE;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_m_vld) begin
                        // M goes first; an E aimed at the same register is dropped (valM wins)
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = dstM;
                        w_wr_data_nxt = valM;
                        w_set_a       = dstM;
                        if (w_e_vld && (dstE != dstM)) begin
                            w_hold_load = 1'b1;
                            w_set_b     = dstE;
                            w_state_nxt = SECOND;
                        end
                    end else if (w_e_vld) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = dstE;
                        w_wr_data_nxt = valE;
                        w_set_a       = dstE;
                    end
                end
            end
            SECOND: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_hold_addr;
                w_wr_data_nxt = r_hold_data;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int r = 0; r < NREG; r++) begin
            if ((w_set_a == 4'(r)) || (w_set_b == 4'(r))) w_set_mask[r] = 1'b1;
            if (r_wr_en && (r_wr_addr == 4'(r)))          w_clr_mask[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold_addr <= REG_NONE;
            r_hold_data <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= REG_NONE;
            r_wr_data   <= '0;
            r_pending   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            // set after clear so a re-write of the register being committed stays pending
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            if (w_hold_load) begin
                r_hold_addr <= dstE;
                r_hold_data <= valE;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign pending = r_pending;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, single/dual/equal-destination
// requests, reset during SECOND and back-to-back pending overlap.
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic [14:0] pending;

    int checks = 0;
    int errors = 0;

    regfile_wb_sched #(.DATA_W(64), .NREG(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .dstE     (dstE),
        .valE     (valE),
        .dstM     (dstM),
        .valM     (valM),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
        wb_valid = v;
        dstE     = de;
        valE     = ve;
        dstM     = dm;
        valM     = vm;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [3:0] a,
                          input logic [63:0] d, input logic [14:0] p);
        chk({tag, "_en"},   64'(wr_en),   64'(en));
        chk({tag, "_addr"}, 64'(wr_addr), 64'(a));
        chk({tag, "_data"}, wr_data,      d);
        chk({tag, "_pend"}, 64'(pending), 64'(p));
    endtask

    initial begin
        rst_n = 1'b0;
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);

        // reset held two cycles
        tick();
        tick();
        chk_wr("rst", 1'b0, 4'hF, 64'h0, 15'h0);
        chk("rst_ready", 64'(wb_ready), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(wb_ready), 64'h1);

        // single E write
        req(1'b1, 4'h3, 64'h11, 4'hF, 64'h0);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("single_t1", 1'b1, 4'h3, 64'h11, 15'h0008);
        chk("single_t1_ready", 64'(wb_ready), 64'h1);
        tick();
        chk_wr("single_t2", 1'b0, 4'hF, 64'h0, 15'h0);

        // dual write: M first, then held E
        req(1'b1, 4'h4, 64'h100, 4'h0, 64'hAB);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("dual_t1", 1'b1, 4'h0, 64'hAB, 15'h0011);
        chk("dual_t1_ready", 64'(wb_ready), 64'h0);
        tick();
        chk_wr("dual_t2", 1'b1, 4'h4, 64'h100, 15'h0010);
        chk("dual_t2_ready", 64'(wb_ready), 64'h1);
        tick();
        chk_wr("dual_t3", 1'b0, 4'hF, 64'h0, 15'h0);

        // equal destination: M wins, single write
        req(1'b1, 4'h4, 64'h8, 4'h4, 64'h55);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("eq_t1", 1'b1, 4'h4, 64'h55, 15'h0010);
        chk("eq_t1_ready", 64'(wb_ready), 64'h1);
        tick();
        chk_wr("eq_t2", 1'b0, 4'hF, 64'h0, 15'h0);

        // M-only write to the highest register ID
        req(1'b1, 4'hF, 64'h99, 4'hE, 64'h77);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("monly_t1", 1'b1, 4'hE, 64'h77, 15'h4000);
        tick();
        chk_wr("monly_t2", 1'b0, 4'hF, 64'h0, 15'h0);

        // no-destination request produces nothing
        req(1'b1, 4'hF, 64'h12, 4'hF, 64'h34);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("none_t1", 1'b0, 4'hF, 64'h0, 15'h0);
        chk("none_t1_ready", 64'(wb_ready), 64'h1);

        // reset during SECOND drops the held E write
        req(1'b1, 4'h1, 64'h5, 4'h2, 64'h6);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("rmid_t1", 1'b1, 4'h2, 64'h6, 15'h0006);
        chk("rmid_t1_ready", 64'(wb_ready), 64'h0);
        rst_n = 1'b0;
        tick();
        chk_wr("rmid_t2", 1'b0, 4'hF, 64'h0, 15'h0);
        rst_n = 1'b1;
        #1;
        chk("rmid_idle_ready", 64'(wb_ready), 64'h1);
        tick();
        chk_wr("rmid_t3", 1'b0, 4'hF, 64'h0, 15'h0);

        // back-to-back same register: set wins over clear
        req(1'b1, 4'h2, 64'h21, 4'hF, 64'h0);
        tick();
        chk_wr("b2b_t1", 1'b1, 4'h2, 64'h21, 15'h0004);
        chk("b2b_t1_ready", 64'(wb_ready), 64'h1);
        req(1'b1, 4'h2, 64'h22, 4'hF, 64'h0);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("b2b_t2", 1'b1, 4'h2, 64'h22, 15'h0004);
        tick();
        chk_wr("b2b_t3", 1'b0, 4'hF, 64'h0, 15'h0);

        // dual requests held valid: accepted every other cycle
        req(1'b1, 4'h5, 64'hA5, 4'h6, 64'hB6);
        tick();
        chk_wr("pair_t1", 1'b1, 4'h6, 64'hB6, 15'h0060);
        req(1'b1, 4'h7, 64'hC7, 4'h8, 64'hD8);
        tick();
        chk_wr("pair_t2", 1'b1, 4'h5, 64'hA5, 15'h0020);
        chk("pair_t2_ready", 64'(wb_ready), 64'h1);
        tick();
        req(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        chk_wr("pair_t3", 1'b1, 4'h8, 64'hD8, 15'h0180);
        tick();
        chk_wr("pair_t4", 1'b1, 4'h7, 64'hC7, 15'h0080);
        tick();
        chk_wr("pair_t5", 1'b0, 4'hF, 64'h0, 15'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
